// File: rtl/interrupt_pkg.sv
// Shared types and step encodings for the interrupt entry sequence.
package interrupt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SAFE,
    SEQ,
    ISR
  } int_state_t;

  localparam int STEP_PUSH_PC_HI = 0;
  localparam int STEP_PUSH_PC_LO = 1;
  localparam int STEP_PUSH_FLAGS = 2;
  localparam int STEP_VECTOR     = 3;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer in front of the core.
// Build option IRQ_EDGE_TRIGGER_EN selects edge (vs level) request trigger.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SEQ_LEN     = 4,
  parameter int STEP_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq_req,
  input  logic              stall,
  input  logic              flush_pending,
  input  logic              rti_retire,
  output logic              interrupt_signal,
  output logic [STEP_W-1:0] int_step,
  output logic              int_active,
  output logic              irq_pending
);

  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(SEQ_LEN - 1);

  int_state_t        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              pending_q, pending_d;
  logic              irq_s;
  logic              trigger;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_req),
    .q   (irq_s)
  );

`ifdef IRQ_EDGE_TRIGGER_EN
  logic irq_prev_q;
  logic irq_prev_d;

  always_comb begin
    irq_prev_d = irq_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
    end
  end

  assign trigger = irq_s & ~irq_prev_q;
`else
  assign trigger = irq_s;
`endif

  // Only SEQ entry clears pending, so a new trigger always survives in ISR.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pending_d = pending_q;
    if (trigger) begin
      pending_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = WAIT_SAFE;
        end
      end
      WAIT_SAFE: begin
        if (!stall && !flush_pending) begin
          state_d   = SEQ;
          step_d    = '0;
          pending_d = 1'b0;
        end
      end
      SEQ: begin
        if (!stall) begin
          if (step_q == STEP_LAST) begin
            state_d = ISR;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      ISR: begin
        if (rti_retire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      pending_q <= pending_d;
    end
  end

  assign interrupt_signal = (state_q == SEQ);
  assign int_step         = step_q;
  assign int_active       = (state_q == SEQ) ||
                            (state_q == ISR);
  assign irq_pending      = pending_q;

endmodule
